// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the fetch FSM encoding, the special instruction words and the redirect payload.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } redirect_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_redirect_sel.sv
// Picks the winning control-flow redirect (JR over BRANCH over JUMP).
// Purely combinational; the target is returned word aligned.
module fetch_redirect_sel
  import if_fetch_unit_pkg::*;
(
  input  logic            jr_taken,
  input  logic [XLEN-1:0] jr_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_target,
  output redirect_t       redirect_c
);

  always_comb begin
    redirect_c = '0;
    if (jr_taken) begin
      redirect_c.taken  = 1'b1;
      redirect_c.target = word_align(jr_target);
    end else if (branch_taken) begin
      redirect_c.taken  = 1'b1;
      redirect_c.target = word_align(branch_target);
    end else if (jump_taken) begin
      redirect_c.taken  = 1'b1;
      redirect_c.target = word_align(jump_target);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, stall hold buffer,
// redirect handling with stale-response discard, and halt detection.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            PCWrite,
  input  logic            JR_TAKEN,
  input  logic [XLEN-1:0] JR_TARGET,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            JUMP_TAKEN,
  input  logic [XLEN-1:0] JUMP_TARGET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_VALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic [XLEN-1:0] INSTR_F,
  output logic [XLEN-1:0] PCplus4F,
  output logic            HALTED
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_word;
  logic            discard;
  redirect_t       redirect_c;

  fetch_redirect_sel u_redirect_sel (
    .jr_taken      (JR_TAKEN),
    .jr_target     (JR_TARGET),
    .branch_taken  (BRANCH_TAKEN),
    .branch_target (BRANCH_TARGET),
    .jump_taken    (JUMP_TAKEN),
    .jump_target   (JUMP_TARGET),
    .redirect_c    (redirect_c)
  );

  // INSTR_F and IMEM_REQ are single-cycle pulses: they fall back to idle unless set below.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_RST;
      pc        <= RESET_PC;
      hold_word <= NOP_WORD;
      discard   <= 1'b0;
      IMEM_REQ  <= 1'b0;
      IMEM_ADDR <= '0;
      INSTR_F   <= NOP_WORD;
      PCplus4F  <= '0;
      HALTED    <= 1'b0;
    end else begin
      IMEM_REQ <= 1'b0;
      INSTR_F  <= NOP_WORD;
      case (state)
        ST_RST: state <= ST_ISSUE;

        // A request is launched only once any abandoned response has drained.
        ST_ISSUE: begin
          if (discard && IMEM_VALID) discard <= 1'b0;
          if (redirect_c.taken) begin
            pc <= redirect_c.target;
          end else if (!discard) begin
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= pc;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (redirect_c.taken) begin
            pc        <= redirect_c.target;
            hold_word <= NOP_WORD;
            discard   <= !IMEM_VALID;
            state     <= ST_ISSUE;
          end else if (IMEM_VALID) begin
            if (IMEM_RDATA == HALT_WORD) begin
              HALTED <= 1'b1;
              state  <= ST_HALT;
            end else if (PCWrite) begin
              INSTR_F  <= IMEM_RDATA;
              PCplus4F <= pc + XLEN'(4);
              pc       <= pc + XLEN'(4);
              state    <= ST_ISSUE;
            end else begin
              hold_word <= IMEM_RDATA;
              state     <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (redirect_c.taken) begin
            pc        <= redirect_c.target;
            hold_word <= NOP_WORD;
            state     <= ST_ISSUE;
          end else if (PCWrite) begin
            INSTR_F   <= hold_word;
            PCplus4F  <= pc + XLEN'(4);
            pc        <= pc + XLEN'(4);
            hold_word <= NOP_WORD;
            state     <= ST_ISSUE;
          end
        end

        ST_HALT: state <= ST_HALT;

        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a reference model predicts the delivered
// instruction stream and request addresses; a monitor compares as the DUT produces them.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

  logic        CLOCK;
  logic        RESET_N;
  logic        PCWrite;
  logic        JR_TAKEN, BRANCH_TAKEN, JUMP_TAKEN;
  logic [31:0] JR_TARGET, BRANCH_TARGET, JUMP_TARGET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_VALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR_F;
  logic [31:0] PCplus4F;
  logic        HALTED;

  if_fetch_unit dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .PCWrite       (PCWrite),
    .JR_TAKEN      (JR_TAKEN),
    .JR_TARGET     (JR_TARGET),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP_TAKEN    (JUMP_TAKEN),
    .JUMP_TARGET   (JUMP_TARGET),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_VALID    (IMEM_VALID),
    .IMEM_RDATA    (IMEM_RDATA),
    .INSTR_F       (INSTR_F),
    .PCplus4F      (PCplus4F),
    .HALTED        (HALTED)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    bit          halt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tail_pc;
  bit          tail_halted;
  logic [31:0] halt_addr;
  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  int          halts_seen = 0;
  int          lat_fixed = 1;
  bit          lat_rand = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Program image: a scrambled, never-zero word per address, plus one planted halt word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == halt_addr) return HALT_W;
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    return {1'b0, h[30:1], 1'b1};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Keep a short window of the sequential program ahead of the fetch point.
  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 4 && !tail_halted) begin
      e.addr = tail_pc;
      e.word = mem_word(tail_pc);
      e.halt = (e.word == HALT_W);
      exp_q.push_back(e);
      if (e.halt) tail_halted = 1'b1;
      else        tail_pc = tail_pc + 32'd4;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] t);
    exp_q.delete();
    tail_pc     = t & 32'hFFFF_FFFC;
    tail_halted = 1'b0;
    refill();
  endfunction

  task automatic tick();
    @(negedge CLOCK);
    refill();
  endtask

  task automatic do_redirect(input bit jr, input bit br, input bit jp,
                             input logic [31:0] jt, input logic [31:0] bt, input logic [31:0] pt);
    JR_TAKEN      = jr;  JR_TARGET     = jt;
    BRANCH_TAKEN  = br;  BRANCH_TARGET = bt;
    JUMP_TAKEN    = jp;  JUMP_TARGET   = pt;
    model_restart(jr ? jt : (br ? bt : pt));
    tick();
    JR_TAKEN = 1'b0; BRANCH_TAKEN = 1'b0; JUMP_TAKEN = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n = 0;
    while (!IMEM_REQ && n < 60) begin
      tick();
      n++;
    end
    if (!IMEM_REQ) fail_now({name, " (no request within bound)"});
    else           check32(name, IMEM_ADDR, exp_addr);
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFE0 | ($urandom & 32'h1F);
    return $urandom & 32'h0000_0FFF;
  endfunction

  // Memory: one response, 'lat' cycles after each request, dropped on reset.
  initial begin
    int          pend;
    logic [31:0] pend_addr;
    pend       = 0;
    pend_addr  = '0;
    IMEM_VALID = 1'b0;
    IMEM_RDATA = '0;
    forever begin
      @(negedge CLOCK);
      IMEM_VALID = 1'b0;
      IMEM_RDATA = '0;
      if (!RESET_N) begin
        pend = 0;
      end else begin
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            IMEM_VALID = 1'b1;
            IMEM_RDATA = mem_word(pend_addr);
          end
        end
        if (IMEM_REQ) begin
          checks++;
          if (pend != 0) begin
            errors++;
            $display("FAIL one_outstanding: request %h while %h still pending at %0t",
                     IMEM_ADDR, pend_addr, $time);
          end
          pend      = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
          pend_addr = IMEM_ADDR;
        end
      end
    end
  end

  // Monitor: compare every delivered word, halt event and request address against the model.
  initial begin
    logic [31:0] prev_instr;
    logic        prev_halted;
    prev_instr  = '0;
    prev_halted = 1'b0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (!RESET_N) begin
        prev_instr  = '0;
        prev_halted = 1'b0;
      end else begin
        if (INSTR_F != 32'h0) begin
          deliveries++;
          check32("bubble_before_instr", prev_instr, 32'h0);
          if (exp_q.size() == 0 || exp_q[0].halt) begin
            fail_now("unexpected_instr");
          end else begin
            check32("instr_f", INSTR_F, exp_q[0].word);
            check32("pcplus4f", PCplus4F, exp_q[0].addr + 32'd4);
            void'(exp_q.pop_front());
          end
        end
        if (HALTED && !prev_halted) begin
          halts_seen++;
          check32("instr_at_halt", INSTR_F, 32'h0);
          if (exp_q.size() == 0 || !exp_q[0].halt) fail_now("halt_not_expected");
          else void'(exp_q.pop_front());
        end
        if (IMEM_REQ) begin
          if (HALTED || exp_q.size() == 0) fail_now("request_when_none_expected");
          else check32("imem_addr", IMEM_ADDR, exp_q[0].addr);
        end
        prev_instr  = INSTR_F;
        prev_halted = HALTED;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    int d0;
    RESET_N = 1'b0;
    PCWrite = 1'b1;
    JR_TAKEN = 1'b0; BRANCH_TAKEN = 1'b0; JUMP_TAKEN = 1'b0;
    JR_TARGET = '0;  BRANCH_TARGET = '0;  JUMP_TARGET = '0;
    halt_addr = 32'h0000_0001;
    model_restart(RESET_PC);

    repeat (3) tick();
    check32("rst_instr_f", INSTR_F, 32'h0);
    check32("rst_pcplus4f", PCplus4F, 32'h0);
    check32("rst_imem_req", 32'(IMEM_REQ), 32'h0);
    check32("rst_imem_addr", IMEM_ADDR, 32'h0);
    check32("rst_halted", 32'(HALTED), 32'h0);
    #3 RESET_N = 1'b1;

    // Single-cycle memory, then a three-cycle stall while the word at 0x8 returns.
    lat_fixed = 1;
    n = 0;
    while (!(IMEM_REQ && IMEM_ADDR == 32'h8) && n < 60) begin
      tick();
      n++;
    end
    if (!(IMEM_REQ && IMEM_ADDR == 32'h8)) fail_now("stall_setup (no request for 0x8)");
    PCWrite = 1'b0;
    repeat (3) begin
      tick();
      check32("stall_instr_f", INSTR_F, 32'h0);
      check32("stall_no_req", 32'(IMEM_REQ), 32'h0);
    end
    PCWrite = 1'b1;
    tick();
    check32("stall_release_instr", INSTR_F, mem_word(32'h8));
    check32("stall_release_pc4", PCplus4F, 32'hC);

    // Simultaneous JR and BRANCH: JR wins.
    repeat (2) tick();
    do_redirect(1'b1, 1'b1, 1'b0, 32'h80, 32'h40, 32'h0);
    wait_req(32'h80, "priority_jr_addr");

    // Branch while a slow read is outstanding: the stale word must be dropped.
    lat_fixed = 3;
    tick();
    n = 0;
    while (!IMEM_REQ && n < 60) begin
      tick();
      n++;
    end
    tick();
    do_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
    wait_req(32'h100, "discard_branch_addr");

    // Asynchronous reset while waiting on memory.
    repeat (4) tick();
    n = 0;
    while (!IMEM_REQ && n < 60) begin
      tick();
      n++;
    end
    @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check32("areset_instr_f", INSTR_F, 32'h0);
    check32("areset_pcplus4f", PCplus4F, 32'h0);
    check32("areset_imem_req", 32'(IMEM_REQ), 32'h0);
    check32("areset_imem_addr", IMEM_ADDR, 32'h0);
    check32("areset_halted", 32'(HALTED), 32'h0);
    model_restart(RESET_PC);
    repeat (2) tick();
    #3 RESET_N = 1'b1;
    wait_req(RESET_PC, "post_reset_addr");

    // Randomized latency, stalls and redirects (including near-wrap targets).
    lat_rand = 1'b1;
    d0 = deliveries;
    for (int i = 0; i < 800; i++) begin
      PCWrite = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        logic [2:0] sel;
        sel = 3'($urandom_range(1, 7));
        do_redirect(sel[2], sel[1], sel[0], rand_target(), rand_target(), rand_target());
      end else begin
        tick();
      end
    end
    PCWrite = 1'b1;
    repeat (40) tick();
    checks++;
    if (deliveries - d0 < 20) begin
      errors++;
      $display("FAIL random_progress: got %0d deliveries expected at least 20", deliveries - d0);
    end

    // Halt word at 0x208; later jumps must not restart fetch.
    lat_rand  = 1'b0;
    lat_fixed = 1;
    halt_addr = 32'h208;
    do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200);
    n = 0;
    while (!HALTED && n < 100) begin
      tick();
      n++;
    end
    check32("halted_set", 32'(HALTED), 32'h1);
    JUMP_TAKEN  = 1'b1;
    JUMP_TARGET = 32'h40;
    repeat (8) begin
      tick();
      check32("halt_no_req", 32'(IMEM_REQ), 32'h0);
    end
    JUMP_TAKEN = 1'b0;
    tick();
    check32("halted_sticky", 32'(HALTED), 32'h1);
    check32("halt_count", 32'(halts_seen), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
